// File: rtl/fp32_addsub_seq_if.sv
// Valid/ready operand and result channels of the iterative FP32 adder/subtractor.
// The master supplies operands and accepts results; the slave is the arithmetic block.
interface fp32_addsub_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    modport master (
        output in_valid, a, b, op_sub, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b, op_sub, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/fp32_addsub_seq.sv
// Iterative FP32 a+b / a-b: one right-shift per cycle for alignment, one shift per cycle
// for normalization, a single 25-bit add/sub, truncating rounding, denormals flushed to zero.
module fp32_addsub_seq #(
    parameter int unsigned ALIGN_MAX = 26,
    parameter logic [31:0] QNAN      = 32'h7FC0_0000
) (
    input  logic              clk,
    input  logic              rst,
    fp32_addsub_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADDSUB,
        S_NORM,
        S_DONE
    } state_t;

    localparam logic [7:0] ALIGN_CLAMP = 8'(ALIGN_MAX);

    // Control and visible outputs
    state_t      state;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;
    logic [31:0] result_q;

    // Datapath working registers; X is the larger-magnitude operand
    logic        sign_x;
    logic        sign_y;
    logic [7:0]  exp_x;
    logic [23:0] man_x;
    logic [23:0] man_y;
    logic [7:0]  shift_cnt;
    logic [24:0] sum;

    // Operand unpack and add/sub terms
    logic        sign_a;
    logic        sign_b;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [23:0] man_a;
    logic [23:0] man_b;
    logic        is_nan;
    logic        a_ge_b;
    logic [7:0]  exp_diff;
    logic [7:0]  align_cnt;
    logic [24:0] sum_next;

    // NOTE: every signal here is assigned on every pass through the block, so no latch is inferred.
    always_comb begin
        exp_a     = bus.a[30:23];
        exp_b     = bus.b[30:23];
        sign_a    = bus.a[31];
        sign_b    = bus.b[31] ^ bus.op_sub;
        man_a     = (exp_a != 8'd0) ? {1'b1, bus.a[22:0]} : 24'd0;
        man_b     = (exp_b != 8'd0) ? {1'b1, bus.b[22:0]} : 24'd0;
        is_nan    = (exp_a == 8'hFF) || (exp_b == 8'hFF);
        a_ge_b    = {exp_a, man_a} >= {exp_b, man_b};
        exp_diff  = a_ge_b ? (exp_a - exp_b) : (exp_b - exp_a);
        align_cnt = (exp_diff > ALIGN_CLAMP) ? ALIGN_CLAMP : exp_diff;
        // X >= Y in magnitude, so the difference never goes negative
        sum_next  = (sign_x == sign_y) ? ({1'b0, man_x} + {1'b0, man_y})
                                       : ({1'b0, man_x} - {1'b0, man_y});
    end

    // NOTE: only control state and visible outputs are reset; the datapath registers are always
    // loaded before they are read, so resetting them would add reset fan-out for no benefit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= 32'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (is_nan) begin
                            result_q    <= QNAN;
                            out_valid_q <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            if (a_ge_b) begin
                                sign_x <= sign_a;
                                exp_x  <= exp_a;
                                man_x  <= man_a;
                                sign_y <= sign_b;
                                man_y  <= man_b;
                            end else begin
                                sign_x <= sign_b;
                                exp_x  <= exp_b;
                                man_x  <= man_b;
                                sign_y <= sign_a;
                                man_y  <= man_a;
                            end
                            shift_cnt <= align_cnt;
                            state     <= (align_cnt != 8'd0) ? S_ALIGN : S_ADDSUB;
                        end
                    end
                end

                S_ALIGN: begin
                    // Bits falling off the right are dropped: truncation, no guard/sticky
                    man_y     <= man_y >> 1;
                    shift_cnt <= shift_cnt - 8'd1;
                    if (shift_cnt == 8'd1) begin
                        state <= S_ADDSUB;
                    end
                end

                S_ADDSUB: begin
                    sum <= sum_next;
                    if (sum_next == 25'd0) begin
                        result_q    <= 32'd0;
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        state <= S_NORM;
                    end
                end

                S_NORM: begin
                    if (sum[24]) begin
                        if (exp_x == 8'd254) begin
                            result_q    <= {sign_x, 8'hFF, 23'd0};
                            out_valid_q <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            sum   <= sum >> 1;
                            exp_x <= exp_x + 8'd1;
                        end
                    end else if (!sum[23]) begin
                        // Result would be denormal: flush to +0
                        if (exp_x == 8'd1) begin
                            result_q    <= 32'd0;
                            out_valid_q <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            sum   <= sum << 1;
                            exp_x <= exp_x - 8'd1;
                        end
                    end else begin
                        result_q    <= {sign_x, exp_x, sum[22:0]};
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_fp32_addsub_seq.sv
// Self-checking bench for fp32_addsub_seq: directed corner cases plus randomized operands
// compared against an arithmetic reference model that also predicts latency.
module tb_fp32_addsub_seq;

    localparam logic [31:0] QNAN  = 32'h7FC0_0000;
    localparam int          LIMIT = 100;

    logic clk = 1'b0;
    logic rst;

    fp32_addsub_seq_if bus ();

    fp32_addsub_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Value semantics: magnitude compare, align by exponent difference, add or subtract,
    // then place the leading one at bit 23 and apply the exponent range limits.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                      output logic [31:0] res, output int lat);
        int ea, eb, ex, ey, ma, mb, mx, my, d, s, p, k, e;
        logic sa, sb, sx, sy;
        logic [31:0] t;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) begin
            res = QNAN;
            lat = 1;
            return;
        end
        sa = a[31];
        sb = b[31] ^ sub;
        ma = (ea != 0) ? ((1 << 23) | int'(a[22:0])) : 0;
        mb = (eb != 0) ? ((1 << 23) | int'(b[22:0])) : 0;
        if (ea > eb || (ea == eb && ma >= mb)) begin
            ex = ea; mx = ma; sx = sa; ey = eb; my = mb; sy = sb;
        end else begin
            ex = eb; mx = mb; sx = sb; ey = ea; my = ma; sy = sa;
        end
        d = ex - ey;
        if (d > 26) d = 26;
        my = my >> d;
        s  = (sx == sy) ? (mx + my) : (mx - my);
        if (s == 0) begin
            res = 32'd0;
            lat = 2 + d;
            return;
        end
        p = 0;
        for (int i = 0; i < 25; i++) begin
            if (((s >> i) & 1) != 0) p = i;
        end
        if (p == 24) begin
            e = ex + 1;
            if (e >= 255) begin
                res = {sx, 8'hFF, 23'd0};
                lat = 3 + d;
            end else begin
                t   = 32'(s >> 1);
                res = {sx, 8'(e), t[22:0]};
                lat = 4 + d;
            end
        end else begin
            k = 23 - p;
            if (ex - k >= 1) begin
                t   = 32'(s << k);
                res = {sx, 8'(ex - k), t[22:0]};
                lat = 3 + d + k;
            end else begin
                res = 32'd0;
                lat = 3 + d + (ex - 1);
            end
        end
    endfunction

    task automatic apply_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one operation from IDLE, measure latency, hold the result for 'hold' cycles
    // with stray in_valid pulses, then complete the result handshake.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input int hold);
        logic [31:0] exp_res;
        int exp_lat;
        int lat;
        ref_model(a, b, sub, exp_res, exp_lat);
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.op_sub   = sub;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) begin
            check({tag, ".timeout"}, 32'(bus.out_valid), 32'd1);
            apply_reset();
            return;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".result"}, bus.result, exp_res);
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = i[0];
            bus.a        = $urandom;
            bus.b        = $urandom;
            @(negedge clk);
            check({tag, ".hold_result"}, bus.result, exp_res);
            check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, ".hold_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    function automatic logic [31:0] rand_fp(input int base_exp);
        int e;
        int r;
        logic [22:0] frac;
        r = int'($urandom_range(0, 15));
        if (r == 0)      e = 0;
        else if (r == 1) e = 255;
        else begin
            e = base_exp + int'($urandom_range(0, 8)) - 4;
            if (e < 0)   e = 0;
            if (e > 254) e = 254;
        end
        frac = 23'($urandom);
        if ($urandom_range(0, 3) == 0) frac = 23'($urandom_range(0, 3));
        return {1'($urandom), 8'(e), frac};
    endfunction

    initial begin
        logic [31:0] ra, rb;
        int base;

        bus.in_valid  = 1'b0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.result", bus.result, 32'd0);

        run_op("sub_3_1",     32'h4040_0000, 32'h3F80_0000, 1'b1, 0);
        run_op("add_carry",   32'h3F80_0000, 32'h3F80_0000, 1'b0, 0);
        run_op("add_ovf",     32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 0);
        run_op("sub_zero",    32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 0);
        run_op("sub_cancel",  32'h3F80_0001, 32'h3F80_0000, 1'b1, 0);
        run_op("align_clamp", 32'h4F80_0000, 32'h3F80_0000, 1'b1, 0);
        run_op("nan_in",      32'h7F80_0000, 32'h1234_5678, 1'b0, 0);
        run_op("denorm",      32'h0000_0005, 32'h3F80_0000, 1'b0, 0);
        run_op("flush",       32'h0100_0001, 32'h0100_0000, 1'b1, 0);
        run_op("backpress",   32'h4040_0000, 32'h3F80_0000, 1'b1, 5);

        // Abort an operation mid-alignment
        bus.a        = 32'h4F80_0000;
        bus.b        = 32'h3F80_0000;
        bus.op_sub   = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort.busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort.out_valid", 32'(bus.out_valid), 32'd0);
        check("abort.in_ready", 32'(bus.in_ready), 32'd1);
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.result", bus.result, 32'd0);
        run_op("after_abort", 32'h4040_0000, 32'h3F80_0000, 1'b1, 0);

        for (int n = 0; n < 300; n++) begin
            base = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6))
                                               : int'($urandom_range(1, 254));
            ra = rand_fp(base);
            rb = rand_fp(base);
            if ($urandom_range(0, 3) == 0) begin
                rb = {1'($urandom), ra[30:0] ^ 31'($urandom_range(0, 7))};
            end
            run_op("rand", ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
